// File: rtl/nios2_jtag_host_pkg.sv
// Shared types and constants for the Nios II host-side virtual-JTAG scan initiator.
package nios2_jtag_host_pkg;

  localparam int unsigned DR_WIDTH_DEFAULT = 38;
  localparam int unsigned IR_WIDTH         = 2;

  localparam logic [IR_WIDTH-1:0] IR_OCIMEM    = 2'b00;
  localparam logic [IR_WIDTH-1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [IR_WIDTH-1:0] IR_BREAK     = 2'b10;
  localparam logic [IR_WIDTH-1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_UDR  = 3'd4,
    S_RTI  = 3'd5
  } state_e;

endpackage

// File: rtl/nios2_jtag_host_tckgen.sv
// TCK divider: TCK_DIV clk cycles low then TCK_DIV high, restarting low whenever run rises.
module nios2_jtag_host_tckgen #(
  parameter int unsigned TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  output logic o_tck,
  output logic o_tck_rise_c,
  output logic o_tck_fall_c
);

  localparam int unsigned CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_run_q;
  logic          r_tck;
  logic          w_en;
  logic          w_wrap;

  // Counting starts one cycle after run rises, giving the FSM a launch cycle.
  assign w_en         = i_run && r_run_q;
  assign w_wrap       = w_en && (r_cnt == CW'(TCK_DIV - 1));
  assign o_tck_rise_c = w_wrap && !r_tck;
  assign o_tck_fall_c = w_wrap && r_tck;
  assign o_tck        = r_tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_run_q <= 1'b0;
      r_tck   <= 1'b0;
    end else begin
      r_run_q <= i_run;
      if (!w_en) begin
        r_cnt <= '0;
        r_tck <= 1'b0;
      end else if (w_wrap) begin
        r_cnt <= '0;
        r_tck <= ~r_tck;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nios2_jtag_host_scan.sv
// Host-side virtual-JTAG scan initiator: one command -> UIR/CDR/SDR/UDR/RTI with generated TCK.
// Optional NIOS2_JTAG_HOST_IR_CAPTURE_EN adds rsp_ir_out, sampled from vji_ir_out in UIR.
module nios2_jtag_host_scan
  import nios2_jtag_host_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int unsigned TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  input  logic                cmd_ir_only,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic [1:0]          vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  input  logic                vji_tdo,
  input  logic [1:0]          vji_ir_out
`ifdef NIOS2_JTAG_HOST_IR_CAPTURE_EN
  ,
  output logic [1:0]          rsp_ir_out
`endif
);

  localparam int unsigned BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DR_WIDTH-1:0] r_sr;
  logic [BW-1:0]       r_bitcnt;
  logic                r_ir_only;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [DR_WIDTH-1:0] r_rsp_dr;
  logic                r_tdi;
  logic [1:0]          r_ir_in;
  logic                r_uir, r_cdr, r_sdr, r_udr, r_rti;
  logic                w_accept;
  logic                w_run;
  logic                w_rise;
  logic                w_fall;

  assign w_accept = cmd_valid && r_cmd_ready;
  assign w_run    = (r_state != S_IDLE);

  nios2_jtag_host_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_run        (w_run),
    .o_tck        (vji_tck),
    .o_tck_rise_c (w_rise),
    .o_tck_fall_c (w_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Every phase ends on the TCK falling edge that closes its last period.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_UIR;
      S_UIR:   if (w_fall) w_state_nxt = r_ir_only ? S_RTI : S_CDR;
      S_CDR:   if (w_fall) w_state_nxt = S_SDR;
      S_SDR:   if (w_fall && (r_bitcnt == '0)) w_state_nxt = S_UDR;
      S_UDR:   if (w_fall) w_state_nxt = S_RTI;
      S_RTI:   if (w_fall) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr        <= '0;
      r_bitcnt    <= '0;
      r_ir_only   <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_dr    <= '0;
      r_tdi       <= 1'b0;
      r_ir_in     <= '0;
      r_uir       <= 1'b0;
      r_cdr       <= 1'b0;
      r_sdr       <= 1'b0;
      r_udr       <= 1'b0;
      r_rti       <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      // UIR strobe is held off during the launch cycle while TCK has not started.
      r_uir       <= (w_state_nxt == S_UIR) && (r_state == S_UIR);
      r_cdr       <= (w_state_nxt == S_CDR);
      r_sdr       <= (w_state_nxt == S_SDR);
      r_udr       <= (w_state_nxt == S_UDR);
      r_rti       <= (w_state_nxt == S_RTI);
      r_rsp_valid <= (r_state == S_RTI) && w_fall;
      if (w_accept) begin
        r_ir_in   <= cmd_ir;
        r_sr      <= cmd_dr;
        r_ir_only <= cmd_ir_only;
        r_bitcnt  <= BW'(DR_WIDTH - 1);
        r_tdi     <= cmd_dr[0];
      end else begin
        if ((r_state == S_SDR) && w_rise) r_sr <= {vji_tdo, r_sr[DR_WIDTH-1:1]};
        if ((r_state == S_SDR) && w_fall) r_bitcnt <= r_bitcnt - BW'(1);
        // TDI only moves on falling TCK so the slave sees it stable at the rise.
        if (w_fall) r_tdi <= r_sr[0];
        if ((r_state == S_RTI) && w_fall) r_rsp_dr <= r_sr;
      end
    end
  end

`ifdef NIOS2_JTAG_HOST_IR_CAPTURE_EN
  logic [1:0] r_ir_cap;
  logic [1:0] r_rsp_ir_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir_cap     <= '0;
      r_rsp_ir_out <= '0;
    end else begin
      if ((r_state == S_UIR) && w_rise) r_ir_cap <= vji_ir_out;
      if ((r_state == S_RTI) && w_fall) r_rsp_ir_out <= r_ir_cap;
    end
  end

  assign rsp_ir_out = r_rsp_ir_out;
`else
  logic w_unused_ir_out;
  assign w_unused_ir_out = ^vji_ir_out;
`endif

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dr    = r_rsp_dr;
  assign vji_tdi   = r_tdi;
  assign vji_ir_in = r_ir_in;
  assign vji_uir   = r_uir;
  assign vji_cdr   = r_cdr;
  assign vji_sdr   = r_sdr;
  assign vji_udr   = r_udr;
  assign vji_rti   = r_rti;

endmodule
